// File: rtl/pmem_responder.sv
// Line-granular backing memory answering pmem_read/pmem_write with a fixed-latency pmem_resp pulse.
// One request in flight; full-line reads and writes.
module pmem_responder #(
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned OFFSET  = 4,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [ADDR_W-1:0] pmem_address,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              proto_err,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               op_wr;
    logic [IDX_W-1:0]   idx;
    logic [LINE_W-1:0]  wdata_q;
    logic [IDX_W-1:0]   req_idx;
    logic [LINE_W-1:0]  mem [DEPTH];

    // Upper address bits beyond the index alias modulo DEPTH.
    assign req_idx = pmem_address[OFFSET +: IDX_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            op_wr      <= 1'b0;
            idx        <= '0;
            wdata_q    <= '0;
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
            proto_err  <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            pmem_resp <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pmem_read || pmem_write) begin
                        // A simultaneous read+write is served as a write and flagged.
                        op_wr   <= pmem_write;
                        idx     <= req_idx;
                        wdata_q <= pmem_wdata;
                        if (pmem_read && pmem_write) begin
                            proto_err <= 1'b1;
                        end
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            pmem_resp <= 1'b1;
                            if (!pmem_write) begin
                                pmem_rdata <= mem[req_idx];
                            end
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= RESP;
                        pmem_resp <= 1'b1;
                        if (!op_wr) begin
                            pmem_rdata <= mem[idx];
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (op_wr) begin
                        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                    end else begin
                        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line commit at the end of a write's RESP cycle; a reset forces IDLE so aborted writes never land.
    always_ff @(posedge clk) begin
        if (state == RESP && op_wr) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: a LATENCY=4 and a LATENCY=1 instance checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_pmem_responder;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         rd   [2];
    logic         wr   [2];
    logic [15:0]  addr [2];
    logic [127:0] wd   [2];
    logic [127:0] rdata[2];
    logic         resp [2];
    logic         perr [2];
    logic [15:0]  rc   [2];
    logic [15:0]  wc   [2];

    int compared = 0;
    int errors   = 0;

    always #5 clk = ~clk;

    pmem_responder #(.LATENCY(4)) u_lat4 (
        .clk(clk), .reset_n(reset_n), .pmem_read(rd[0]), .pmem_write(wr[0]),
        .pmem_address(addr[0]), .pmem_wdata(wd[0]), .pmem_rdata(rdata[0]),
        .pmem_resp(resp[0]), .proto_err(perr[0]), .rd_count(rc[0]), .wr_count(wc[0]));

    pmem_responder #(.LATENCY(1)) u_lat1 (
        .clk(clk), .reset_n(reset_n), .pmem_read(rd[1]), .pmem_write(wr[1]),
        .pmem_address(addr[1]), .pmem_wdata(wd[1]), .pmem_rdata(rdata[1]),
        .pmem_resp(resp[1]), .proto_err(perr[1]), .rd_count(rc[1]), .wr_count(wc[1]));

    task automatic chk(input string nm, input int inst, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, inst, act, exp);
        end
    endtask

    // Transaction-level model: a request accepted at cycle c responds at c+LAT, idle the cycle after.
    int           cyc = 0;
    bit           m_busy   [2];
    int           m_resp_at[2];
    bit           m_wr     [2];
    logic [7:0]   m_idx    [2];
    logic [127:0] m_wd     [2];
    logic [127:0] m_mem    [2][256];
    bit           m_known  [2][256];
    logic [127:0] m_rdata  [2];
    bit           m_rknown [2];
    bit           m_perr   [2];
    int           m_rc     [2];
    int           m_wc     [2];

    function automatic int lat_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    always @(negedge clk) begin
        bit eresp;
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_busy[i] = 1'b0; m_rc[i] = 0; m_wc[i] = 0; m_perr[i] = 1'b0;
                m_rdata[i] = '0; m_rknown[i] = 1'b1;
            end
            eresp = m_busy[i] && (cyc == m_resp_at[i]);
            if (eresp && !m_wr[i]) begin
                m_rknown[i] = m_known[i][m_idx[i]];
                m_rdata[i]  = m_mem[i][m_idx[i]];
            end
            chk("resp", i, 128'(resp[i]), 128'(eresp));
            chk("proto_err", i, 128'(perr[i]), 128'(m_perr[i]));
            chk("rd_count", i, 128'(rc[i]), 128'(m_rc[i]));
            chk("wr_count", i, 128'(wc[i]), 128'(m_wc[i]));
            if (m_rknown[i]) chk("rdata", i, rdata[i], m_rdata[i]);
            if (reset_n) begin
                if (eresp) begin
                    m_busy[i] = 1'b0;
                    if (m_wr[i]) begin
                        m_mem[i][m_idx[i]]   = m_wd[i];
                        m_known[i][m_idx[i]] = 1'b1;
                        if (m_wc[i] < 65535) m_wc[i]++;
                    end else if (m_rc[i] < 65535) begin
                        m_rc[i]++;
                    end
                end else if (!m_busy[i] && (rd[i] || wr[i])) begin
                    m_busy[i]    = 1'b1;
                    m_resp_at[i] = cyc + lat_of(i);
                    m_wr[i]      = wr[i];
                    m_idx[i]     = addr[i][11:4];
                    m_wd[i]      = wd[i];
                    if (rd[i] && wr[i]) m_perr[i] = 1'b1;
                end
            end
        end
        cyc++;
    end

    // Raise a request, hold it until pmem_resp, report latency in cycles (-1 on timeout).
    task automatic txn(input int i, input bit r, input bit w, input logic [15:0] a,
                       input logic [127:0] d, output int lat, output logic [127:0] q);
        @(posedge clk); #1;
        rd[i] = r; wr[i] = w; addr[i] = a; wd[i] = d;
        lat = -1; q = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (resp[i]) begin lat = k; q = rdata[i]; break; end
        end
        @(posedge clk); #1;
        rd[i] = 1'b0; wr[i] = 1'b0;
    endtask

    localparam logic [127:0] L2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] L3 = 128'h3333_0000_1111_2222_4444_5555_6666_7777;
    localparam logic [127:0] L5 = 128'h5555_AAAA_0F0F_F0F0_1234_5678_9ABC_DEF0;
    localparam logic [127:0] L6 = 128'h6666_1000_0000_BEEF_CAFE_F00D_0BAD_D00D;
    localparam logic [127:0] LA = {16{8'hA5}};

    initial begin
        int           lat;
        int           gap;
        int           pulses;
        logic [127:0] q;
        logic [9:0]   pat;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wd[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("reset_resp", 0, 128'(resp[0]), 128'(0));
        chk("reset_rdata", 0, rdata[0], 128'(0));
        chk("reset_rd_count", 0, 128'(rc[0]), 128'(0));

        // Plain write then aliased-offset read of the same line.
        txn(0, 1'b0, 1'b1, 16'h0040, L2, lat, q);
        chk("t2_wr_latency", 0, 128'(lat), 128'(4));
        txn(0, 1'b1, 1'b0, 16'h004F, '0, lat, q);
        chk("t2_rd_latency", 0, 128'(lat), 128'(4));
        chk("t2_rd_line", 0, q, L2);
        @(negedge clk);
        chk("t2_wr_count", 0, 128'(wc[0]), 128'(1));
        chk("t2_rd_count", 0, 128'(rc[0]), 128'(1));

        // write_back then fetch: read raised during RESP is taken only in the following cycle.
        @(posedge clk); #1;
        wr[0] = 1'b1; addr[0] = 16'h0080; wd[0] = L3;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (resp[0]) break;
        end
        #1; wr[0] = 1'b0; rd[0] = 1'b1; addr[0] = 16'h0090;
        gap = -1;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (resp[0]) begin gap = k; break; end
        end
        chk("t3_resp_gap", 0, 128'(gap), 128'(5));
        @(posedge clk); #1 rd[0] = 1'b0;
        pulses = 0;
        repeat (8) begin @(negedge clk); if (resp[0]) pulses++; end
        chk("t3_extra_pulses", 0, 128'(pulses), 128'(0));

        // Read+write together is a write and latches proto_err.
        txn(0, 1'b1, 1'b1, 16'h0100, L5, lat, q);
        @(negedge clk);
        chk("t5_proto_err", 0, 128'(perr[0]), 128'(1));
        txn(0, 1'b1, 1'b0, 16'h0100, '0, lat, q);
        chk("t5_rd_line", 0, q, L5);
        chk("t5_proto_sticky", 0, 128'(perr[0]), 128'(1));

        // Index wraps modulo DEPTH; a read dropped after acceptance still completes.
        txn(0, 1'b0, 1'b1, 16'h1000, L6, lat, q);
        @(posedge clk); #1;
        rd[0] = 1'b1; addr[0] = 16'h0000;
        @(negedge clk);
        @(posedge clk); #1 rd[0] = 1'b0;
        lat = -1;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (resp[0]) begin lat = k; q = rdata[0]; break; end
        end
        chk("t6_drop_latency", 0, 128'(lat), 128'(4));
        chk("t6_alias_line", 0, q, L6);

        // LATENCY=1 with read held: a pulse every second cycle.
        @(posedge clk); #1;
        rd[1] = 1'b1; addr[1] = 16'h0030;
        pat = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            pat[k] = resp[1];
        end
        @(posedge clk); #1 rd[1] = 1'b0;
        @(negedge clk);
        chk("t4_pulse_pattern", 1, 128'(pat), 128'(10'h2AA));
        chk("t4_rd_count", 1, 128'(rc[1]), 128'(5));

        // Reset in cycle 2 of a write aborts it.
        @(posedge clk); #1;
        wr[0] = 1'b1; addr[0] = 16'h0040; wd[0] = LA;
        pulses = 0;
        @(negedge clk); if (resp[0]) pulses++;
        @(posedge clk); #1;
        @(negedge clk); if (resp[0]) pulses++;
        @(posedge clk); #1 reset_n = 1'b0;
        @(negedge clk); if (resp[0]) pulses++;
        @(posedge clk); #1 reset_n = 1'b1; wr[0] = 1'b0;
        repeat (8) begin @(negedge clk); if (resp[0]) pulses++; end
        chk("t1_no_resp", 0, 128'(pulses), 128'(0));
        chk("t1_wr_count", 0, 128'(wc[0]), 128'(0));
        chk("t1_proto_cleared", 0, 128'(perr[0]), 128'(0));
        txn(0, 1'b1, 1'b0, 16'h0040, '0, lat, q);
        chk("t1_line_kept", 0, q, L2);
        @(negedge clk);
        chk("t1_rd_count", 0, 128'(rc[0]), 128'(1));

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end

endmodule
